// File: rtl/noc_pkg.sv
// Shared NoC switch types and helpers: arbiter state encoding,
// round-robin first-eligible search and flit address extraction.
package noc_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    localparam int RR_MAX_IN = 8;

    // Scan from ptr upward, wrapping at n-1; returns ptr when none eligible.
    function automatic logic [2:0] rr_first(
        input logic [7:0] elig,
        input logic [2:0] ptr,
        input int         n
    );
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        idx   = ptr;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_IN; i++) begin
            if (i < n && !found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
        end
        return win;
    endfunction

    function automatic logic [15:0] addr_field(
        input logic [63:0] flit,
        input int          dw,
        input int          aw
    );
        logic [63:0] sh;
        sh = flit >> (dw - aw);
        return sh[15:0] & ((16'd1 << aw) - 16'd1);
    endfunction

endpackage

// File: rtl/noc_port_arbiter_rr_pick.sv
// Combinational rotate-priority picker shared by the switch ports.
// Reports the first eligible index at or after ptr and an any flag.
module rr_pick
    import noc_pkg::*;
#(
    parameter int NumIn = 3
) (
    input  logic [NumIn-1:0]         elig,
    input  logic [$clog2(NumIn)-1:0] ptr,
    output logic [$clog2(NumIn)-1:0] winner,
    output logic                     any_elig
);

    localparam int IdxW = $clog2(NumIn);

    logic [7:0] elig_w;
    logic [2:0] ptr_w;

    always_comb begin
        elig_w              = '0;
        elig_w[NumIn-1:0]   = elig;
        ptr_w               = '0;
        ptr_w[IdxW-1:0]     = ptr;
        winner              = IdxW'(rr_first(elig_w, ptr_w, NumIn));
    end

    assign any_elig = |elig;

endmodule

// File: rtl/noc_port_arbiter.sv
// Round-robin burst arbiter for one switch output port, registered output.
// Define ARB_STATS_EN to add per-input saturating flit counters (o_grant_cnt).
module noc_port_arbiter
    import noc_pkg::*;
#(
    parameter int DataWidth = 36,
    parameter int AddrWidth = 4,
    parameter int NumIn     = 3,
    parameter int DestMin   = 0,
    parameter int DestMax   = 0,
    parameter int MaxBurst  = 4
) (
    input  logic                       i_sclk,
    input  logic                       i_reset_n,
    input  logic [NumIn*DataWidth-1:0] i_req_data,
    input  logic [NumIn-1:0]           i_req_valid,
    output logic [NumIn-1:0]           o_req_ready,
    output logic [DataWidth-1:0]       o_data,
    output logic                       o_data_valid,
    input  logic                       i_data_ready,
    output logic [NumIn-1:0]           o_grant,
    output logic                       o_busy
`ifdef ARB_STATS_EN
    ,
    output logic [NumIn*16-1:0]        o_grant_cnt
`endif
);

    localparam int IdxW = $clog2(NumIn);
    localparam int BcW  = $clog2(MaxBurst + 1);

    arb_state_t              state_q, state_d;
    logic [IdxW-1:0]         ptr_q, ptr_d;
    logic [IdxW-1:0]         owner_q, owner_d;
    logic [IdxW-1:0]         pick;
    logic [BcW-1:0]          cnt_q, cnt_d;
    logic [NumIn-1:0]        elig;
    logic                    any_elig;
    logic                    out_free;
    logic                    xfer;
    logic                    burst_done;
    logic [DataWidth-1:0]    owner_flit;

    always_comb begin
        logic [15:0] addr;
        addr = '0;
        for (int k = 0; k < NumIn; k++) begin
            addr = addr_field(64'(i_req_data[k*DataWidth +: DataWidth]),
                              DataWidth, AddrWidth);
            elig[k] = i_req_valid[k]
                    && int'(addr) >= DestMin
                    && int'(addr) <= DestMax;
        end
    end

    rr_pick #(
        .NumIn    (NumIn)
    ) u_pick (
        .elig     (elig),
        .ptr      (ptr_q),
        .winner   (pick),
        .any_elig (any_elig)
    );

    assign owner_flit = i_req_data[int'(owner_q)*DataWidth +: DataWidth];
    assign out_free   = ~o_data_valid | i_data_ready;
    assign xfer       = (state_q == ARB_HOLD) & elig[owner_q] & out_free;
    assign burst_done = xfer && (cnt_q + BcW'(1) == BcW'(MaxBurst));

    assign o_req_ready = xfer ? (NumIn'(1) << owner_q) : '0;
    assign o_grant     = (state_q == ARB_HOLD) ? (NumIn'(1) << owner_q) : '0;
    assign o_busy      = (state_q == ARB_HOLD);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_elig) begin
                    owner_d = pick;
                    cnt_d   = '0;
                    state_d = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (xfer)
                    cnt_d = cnt_q + BcW'(1);
                // A stalled output never releases; only an idle owner does.
                if (burst_done || (!elig[owner_q] && out_free)) begin
                    state_d = ARB_IDLE;
                    ptr_d   = (owner_q == IdxW'(NumIn - 1))
                            ? '0 : owner_q + IdxW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
        end else if (xfer) begin
            o_data       <= owner_flit;
            o_data_valid <= 1'b1;
        end else if (i_data_ready) begin
            o_data_valid <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] gcnt_q [NumIn];

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NumIn; k++)
                gcnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NumIn; k++)
                if (o_req_ready[k] && gcnt_q[k] != 16'hFFFF)
                    gcnt_q[k] <= gcnt_q[k] + 16'd1;
        end
    end

    always_comb begin
        o_grant_cnt = '0;
        for (int k = 0; k < NumIn; k++)
            o_grant_cnt[k*16 +: 16] = gcnt_q[k];
    end
`endif

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Scoreboard bench for noc_port_arbiter (NumIn=3, MaxBurst=3, dest 0..0).
// Expected flit order and grant patterns are predicted from the stimulus.
module tb_noc_port_arbiter;

    localparam int DW = 36;
    localparam int NI = 3;
    localparam int MB = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NI*DW-1:0]   i_req_data = '0;
    logic [NI-1:0]      i_req_valid = '0;
    logic [NI-1:0]      o_req_ready;
    logic [DW-1:0]      o_data;
    logic               o_data_valid;
    logic               i_data_ready = 1'b1;
    logic [NI-1:0]      o_grant;
    logic               o_busy;
`ifdef ARB_STATS_EN
    logic [NI*16-1:0]   o_grant_cnt;
`endif

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] src0[$];
    logic [DW-1:0] src1[$];
    logic [DW-1:0] src2[$];
    logic [NI-1:0] gseq[$];

    noc_port_arbiter #(
        .DataWidth    (DW),
        .AddrWidth    (4),
        .NumIn        (NI),
        .DestMin      (0),
        .DestMax      (0),
        .MaxBurst     (MB)
    ) dut (
        .i_sclk       (clk),
        .i_reset_n    (rst_n),
        .i_req_data   (i_req_data),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_grant      (o_grant),
        .o_busy       (o_busy)
`ifdef ARB_STATS_EN
        ,
        .o_grant_cnt  (o_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk(int k, int a, int s);
        return {4'(a), 8'(k), 24'(s)};
    endfunction

    task automatic refresh();
        logic [NI*DW-1:0] d;
        d = '0;
        i_req_valid[0] = src0.size() > 0;
        i_req_valid[1] = src1.size() > 0;
        i_req_valid[2] = src2.size() > 0;
        if (src0.size() > 0) d[0*DW +: DW] = src0[0];
        if (src1.size() > 0) d[1*DW +: DW] = src1[0];
        if (src2.size() > 0) d[2*DW +: DW] = src2[0];
        i_req_data = d;
    endtask

    task automatic cycle();
        logic [NI-1:0] rdy;
        logic [NI-1:0] el;
        logic [DW-1:0] exp_f;
        @(negedge clk);
        rdy = o_req_ready;
        gseq.push_back(o_grant);
        for (int k = 0; k < NI; k++)
            el[k] = i_req_valid[k] && (i_req_data[k*DW+32 +: 4] == 4'd0);
        tests++;
        if (!$onehot0(rdy) || (rdy & ~el) != '0) begin
            fails++;
            $display("FAIL ready_legal: o_req_ready=%b eligible=%b", rdy, el);
        end
        if (o_data_valid && i_data_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: o_data=%h, expected no flit", o_data);
            end else begin
                exp_f = sb.pop_front();
                if (o_data !== exp_f) begin
                    fails++;
                    $display("FAIL sb_data: o_data=%h expected %h", o_data, exp_f);
                end
            end
        end
        @(posedge clk);
        #1;
        if (rdy[0] && src0.size() > 0) void'(src0.pop_front());
        if (rdy[1] && src1.size() > 0) void'(src1.pop_front());
        if (rdy[2] && src2.size() > 0) void'(src2.pop_front());
        refresh();
    endtask

    task automatic drain(input string nm, input int max);
        int n;
        n = 0;
        while ((sb.size() != 0 || o_data_valid) && n < max) begin
            cycle();
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d flits outstanding, expected 0",
                     nm, sb.size());
        end
    endtask

    task automatic check_grants(input string nm, input logic [NI-1:0] eg[$]);
        for (int i = 0; i < eg.size(); i++) begin
            tests++;
            if (i >= gseq.size()) begin
                fails++;
                $display("FAIL %s_grant[%0d]: none recorded, expected %b",
                         nm, i, eg[i]);
            end else if (gseq[i] !== eg[i]) begin
                fails++;
                $display("FAIL %s_grant[%0d]: o_grant=%b expected %b",
                         nm, i, gseq[i], eg[i]);
            end
        end
    endtask

    task automatic check_zero(input string nm);
        tests++;
        if (o_grant !== '0 || o_busy !== 1'b0 || o_data_valid !== 1'b0 ||
            o_data !== '0 || o_req_ready !== '0) begin
            fails++;
            $display("FAIL %s: grant=%b busy=%b valid=%b data=%h ready=%b, expected all 0",
                     nm, o_grant, o_busy, o_data_valid, o_data, o_req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_data_ready = 1'b1;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;
        cycle();
        check_zero("post_reset_idle");
    endtask

    task automatic test_rotation();
        logic [NI-1:0] eg[$];
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NI; k++) begin
                eg.push_back('0);
                for (int j = 0; j < MB; j++) begin
                    sb.push_back(mk(k, 0, r*MB + j));
                    eg.push_back(NI'(1) << k);
                end
            end
        for (int s = 0; s < 2*MB; s++) begin
            src0.push_back(mk(0, 0, s));
            src1.push_back(mk(1, 0, s));
            src2.push_back(mk(2, 0, s));
        end
        refresh();
        gseq.delete();
        drain("rotation", 100);
        check_grants("rotation", eg);
    endtask

    task automatic test_eligibility();
        src0.push_back(mk(0, 1, 0));
        src0.push_back(mk(0, 1, 1));
        src1.push_back(mk(1, 0, 0));
        src1.push_back(mk(1, 0, 1));
        sb.push_back(mk(1, 0, 0));
        sb.push_back(mk(1, 0, 1));
        refresh();
        drain("elig", 40);
        repeat (3) cycle();
        tests++;
        if (src0.size() != 2) begin
            fails++;
            $display("FAIL elig_in0_kept: %0d flits left, expected 2", src0.size());
        end
        src0.delete();
        refresh();
    endtask

    task automatic test_backpressure();
        logic [NI-1:0] eg[$];
        for (int s = 10; s < 14; s++) begin
            src0.push_back(mk(0, 0, s));
            sb.push_back(mk(0, 0, s));
        end
        refresh();
        cycle();
        cycle();
        i_data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            tests++;
            if (o_data !== mk(0, 0, 10) || o_data_valid !== 1'b1 ||
                o_req_ready !== '0 || o_grant !== 3'b001 || o_busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_stall[%0d]: data=%h valid=%b ready=%b grant=%b busy=%b, expected %h 1 000 001 1",
                         i, o_data, o_data_valid, o_req_ready, o_grant, o_busy,
                         mk(0, 0, 10));
            end
        end
        i_data_ready = 1'b1;
        gseq.delete();
        drain("bp", 40);
        eg = '{3'b001, 3'b001, 3'b000, 3'b001};
        check_grants("bp_resume", eg);
    endtask

    task automatic test_owner_drop();
        logic [NI-1:0] eg[$];
        src1.push_back(mk(1, 0, 20));
        src2.push_back(mk(2, 0, 21));
        src2.push_back(mk(2, 0, 22));
        src0.push_back(mk(0, 0, 23));
        for (int s = 20; s < 24; s++)
            sb.push_back(mk(s == 20 ? 1 : (s == 23 ? 0 : 2), 0, s));
        refresh();
        gseq.delete();
        drain("drop", 40);
        eg = '{3'b000, 3'b010, 3'b010, 3'b000, 3'b100};
        check_grants("drop", eg);
    endtask

    task automatic test_reset_mid_burst();
        logic [NI-1:0] eg[$];
        for (int s = 30; s < 40; s++)
            src1.push_back(mk(1, 0, s));
        sb.push_back(mk(1, 0, 30));
        sb.push_back(mk(1, 0, 31));
        refresh();
        repeat (3) cycle();
        tests++;
        if (o_busy !== 1'b1 || o_data_valid !== 1'b1 || o_grant !== 3'b010) begin
            fails++;
            $display("FAIL mid_burst_setup: busy=%b valid=%b grant=%b, expected 1 1 010",
                     o_busy, o_data_valid, o_grant);
        end
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_burst");
        sb.delete();
        src1.delete();
        refresh();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        src0.push_back(mk(0, 0, 40));
        src0.push_back(mk(0, 0, 41));
        src1.push_back(mk(1, 0, 42));
        src1.push_back(mk(1, 0, 43));
        for (int s = 40; s < 44; s++)
            sb.push_back(mk(s < 42 ? 0 : 1, 0, s));
        refresh();
        gseq.delete();
        drain("post_reset", 40);
        eg = '{3'b000, 3'b001};
        check_grants("post_reset", eg);
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        tests++;
        if (o_grant_cnt !== {16'd0, 16'd2, 16'd2}) begin
            fails++;
            $display("FAIL stats: o_grant_cnt=%h expected %h",
                     o_grant_cnt, {16'd0, 16'd2, 16'd2});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_eligibility();
        test_backpressure();
        test_owner_drop();
        test_reset_mid_burst();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Round-robin, packet-burst-aware arbiter that shares one switch output port among NumIn input FIFOs in the synchronous B-tree NoC.
- Sits between the input packet buffers and an output packet buffer. It replaces the ad hoc per-output toggling selectors with a scalable scheduler.
- Provides address-range eligibility filtering, a bounded burst hold per grant, and a registered output stage.

Parameters:
- DataWidth, 36, flit width; destination address in the top AddrWidth bits.
- AddrWidth, 4, destination address field width.
- NumIn, 3, number of requesting inputs (2..8).
- DestMin, 0, lowest destination address routed to this port (inclusive).
- DestMax, 0, highest destination address routed to this port (inclusive).
- MaxBurst, 4, maximum flits accepted from one owner per grant (1..255).

Ports:
- i_sclk  input  1  switch clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_req_data  input  NumIn*DataWidth  flit of input k at bits [k*DataWidth +: DataWidth].
- i_req_valid  input  NumIn  per-input flit available.
- o_req_ready  output  NumIn  per-input flit consumed this cycle.
- o_data  output  DataWidth  registered output flit.
- o_data_valid  output  1  output flit valid.
- i_data_ready  input  1  downstream output buffer ready.
- o_grant  output  NumIn  one-hot current owner; zero when idle.
- o_busy  output  1  FSM in HOLD.

Behaviour:
- Eligibility: elig[k] = i_req_valid[k] & (addr_k >= DestMin) & (addr_k <= DestMax), where addr_k is the top AddrWidth bits of flit k. Ineligible inputs never see ready.
- Output stage: single register. out_free = ~o_data_valid | i_data_ready.
- Transfer: in HOLD, if elig[owner] & out_free, then o_req_ready[owner]=1 and the flit is loaded into the output register. The flit appears on o_data/o_data_valid the next cycle, giving 1-cycle latency.
- o_data_valid clears when i_data_ready=1 and no new load occurs. It holds while i_data_ready=0, and o_data stays stable.
- o_req_ready is never asserted for more than one input. It is never asserted unless the matching i_req_valid is high and the input is eligible.
- FSM states are IDLE and HOLD.
- IDLE:
  - If any elig: owner <= first eligible index searching from ptr upward, with wrap. burst_cnt <= 0. Go to HOLD.
  - No transfer occurs in the IDLE cycle, so there is one bubble per arbitration.
  - If no input is eligible, stay in IDLE.
- HOLD:
  - Each transfer increments burst_cnt.
  - Release when the transfer makes burst_cnt reach MaxBurst, or when elig[owner]=0 while out_free=1. The owner is idle, and a stalled output never causes a release.
  - On release: ptr <= (owner+1) mod NumIn, then go to IDLE.
- Backpressure: while out_free=0, stay in HOLD with burst_cnt unchanged.
- Fairness: with all inputs continuously eligible, grants rotate 0,1,..,NumIn-1. Worst-case wait is (NumIn-1)*(MaxBurst+1) accepted cycles.
- Width rules: burst_cnt is clog2(MaxBurst+1) bits. ptr/owner are clog2(NumIn) bits, with wrap by compare-to-NumIn-1 rather than power-of-2 masking.
- Reset (async, any time, including mid-burst): FSM=IDLE, ptr=0, owner=0, burst_cnt=0, o_data_valid=0, o_data=0, o_grant=0, o_busy=0, o_req_ready=0.
- The in-flight output flit is discarded on reset.

Optional Feature:
- ARB_STATS_EN defined:
  - Adds output o_grant_cnt, NumIn*16 bits.
  - Per-input saturating counters of flits transferred, cleared by reset.
  - Counters saturate at 16'hFFFF.
- ARB_STATS_EN undefined: the port and counters are absent. All other behaviour is identical.

Decomposition:
- Package noc_pkg holds:
  - arbiter state encoding (ARB_IDLE=1'b0, ARB_HOLD=1'b1);
  - function for round-robin first-eligible search;
  - address-field extract helper.
- Sub-module rr_pick: combinational rotate-priority picker. Inputs are elig and ptr; outputs are the winner index and an any-eligible flag. It is reused by other switch ports.

Test Plan:
1. Reset mid-burst: owner=1 with burst_cnt=2, o_data_valid=1, pull i_reset_n low → all outputs 0 in the same cycle; after release, the first grant search starts at input 0.
2. NumIn=3, MaxBurst=2, all eligible, i_data_ready=1 → o_grant sequence 001,001,000,010,010,000,100… with 2 flits each; output flit order is in0,in0,in1,in1,in2,in2.
3. DestMin=DestMax=0: input 0 sends addr 4'h1, input 1 sends addr 4'h0 → only input 1 gets o_req_ready; input 0's flit is never consumed.
4. Backpressure: i_data_ready=0 for 5 cycles mid-burst → o_data stable, o_req_ready=0, burst_cnt frozen, no release. Resume → burst completes with exactly MaxBurst flits.
5. Owner drops valid after 1 of 4 flits with the output free → release next cycle; ptr=owner+1; the next eligible input is granted after one IDLE cycle.
6. ARB_STATS_EN: 70000 flits on input 2 → o_grant_cnt[2] saturates at 16'hFFFF; other counters unaffected.
